// File: rtl/display_mux.sv
// display_mux: time-multiplexes eight 7-segment digits onto one shared
// segment bus. A frame is 8 slots of SCAN_DIV cycles; the first cycle of every
// slot is dead time (all anodes off) so ghosting never reaches the next digit.
// Digit contents and status are snapshotted once per frame, and an error status
// blinks the whole display at a rate of BLINK_FRAMES frames per half-period.
module display_mux #(
   parameter int unsigned SCAN_DIV     = 4,
   parameter int unsigned BLINK_FRAMES = 8,
   parameter logic [6:0]  BLANK_SEG    = 7'b1111111
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [6:0] displays [7:0],
   input  logic [1:0] status,
   output logic [7:0] an,
   output logic [6:0] seg,
   output logic       frame_tick
);

   localparam logic [15:0] CNT_LAST   = 16'(SCAN_DIV - 1);
   localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);
   localparam logic [1:0]  STATUS_ERR = 2'b10;

   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  idx_q, idx_d;
   logic [6:0]  shadow_q [7:0];
   logic [1:0]  shadow_status_q;
   logic [7:0]  blink_cnt_q, blink_cnt_d;
   logic        blink_phase_q, blink_phase_d;
   logic        frame_tick_q;

   logic slot_end;
   logic snap;
   logic err_q;

   assign slot_end = (cnt_q == CNT_LAST);
   assign snap     = slot_end && (idx_q == 3'd7);
   // Blink bookkeeping looks at the status already in the shadow, so a status
   // arriving on the snapshot edge only starts counting from the next frame.
   assign err_q    = (shadow_status_q == STATUS_ERR);

   // Next-state for the scan position and the blink timer.
   always_comb begin
      cnt_d         = slot_end ? 16'd0 : cnt_q + 16'd1;
      idx_d         = slot_end ? idx_q + 3'd1 : idx_q;
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      if (!err_q) begin
         // Outside error both are parked at zero so a new error starts lit.
         blink_cnt_d   = 8'd0;
         blink_phase_d = 1'b0;
      end else if (snap) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = 8'd0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d   = blink_cnt_q + 8'd1;
         end
      end
   end

   // Scan counters, blink state and the end-of-frame pulse.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q         <= 16'd0;
         idx_q         <= 3'd0;
         blink_cnt_q   <= 8'd0;
         blink_phase_q <= 1'b0;
         frame_tick_q  <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         frame_tick_q  <= snap;
      end
   end

   // Frame snapshot of the digit patterns and status; inputs are plain levels.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            shadow_q[i] <= BLANK_SEG;
         end
         shadow_status_q <= 2'b00;
      end else if (snap) begin
         for (int i = 0; i < 8; i++) begin
            shadow_q[i] <= displays[i];
         end
         shadow_status_q <= status;
      end
   end

   // Output decode purely from registered state (reset therefore acts at once).
   always_comb begin
      an  = 8'hFF;
      seg = BLANK_SEG;
      if (cnt_q != 16'd0) begin
         an = ~(8'h01 << idx_q);
         if (!(err_q && blink_phase_q)) begin
            seg = shadow_q[idx_q];
         end
      end
   end

   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_mux.sv
// tb_display_mux: directed frame-by-frame check of display_mux with
// SCAN_DIV=4 and BLINK_FRAMES=2. Expected an/seg/frame_tick for every cycle of
// a frame are queued before the frame runs and popped as the DUT produces them.
module tb_display_mux;

   localparam int          SCAN_DIV     = 4;
   localparam int          BLINK_FRAMES = 2;
   localparam int          FRAME        = 8 * SCAN_DIV;
   localparam logic [6:0]  BLANK        = 7'h7F;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] displays [7:0];
   logic [1:0] status;
   logic [7:0] an;
   logic [6:0] seg;
   logic       frame_tick;

   typedef struct {
      logic [7:0] an;
      logic [6:0] seg;
      logic       tick;
      int         cyc;
   } exp_t;

   exp_t       sb_q [$];
   int         tests    = 0;
   int         fails    = 0;
   int         frame_no = 0;
   logic [6:0] frame_vals [8];
   logic [6:0] pend_disp  [8];
   logic [1:0] pend_status;

   always #5 clock = ~clock;

   display_mux #(
      .SCAN_DIV     (SCAN_DIV),
      .BLINK_FRAMES (BLINK_FRAMES),
      .BLANK_SEG    (BLANK)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .displays   (displays),
      .status     (status),
      .an         (an),
      .seg        (seg),
      .frame_tick (frame_tick)
   );

   task automatic push_exp(input logic [7:0] a, input logic [6:0] s, input logic t, input int c);
      exp_t e;
      e.an   = a;
      e.seg  = s;
      e.tick = t;
      e.cyc  = c;
      sb_q.push_back(e);
   endtask

   // Queue one whole frame: slot c/4, dead on c%4==0, tick on cycle 0 unless
   // this is the first frame after reset.
   task automatic push_frame(input bit blank, input bit first);
      logic [7:0] one;
      one = 8'h01;
      for (int c = 0; c < FRAME; c++) begin
         int  slot;
         bit  dead;
         slot = c / SCAN_DIV;
         dead = (c % SCAN_DIV) == 0;
         push_exp(dead ? 8'hFF : ~(one << slot),
                  (dead || blank) ? BLANK : frame_vals[slot],
                  (c == 0) && !first, c);
      end
   endtask

   task automatic check_now();
      exp_t e;
      if (sb_q.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL sb_empty frame=%0d: got an=%h seg=%h, required a queued expectation", frame_no, an, seg);
      end else begin
         e = sb_q.pop_front();
         tests++;
         assert (an === e.an) else begin
            fails++;
            $error("FAIL an frame=%0d cyc=%0d got=%h exp=%h", frame_no, e.cyc, an, e.an);
         end
         tests++;
         assert (seg === e.seg) else begin
            fails++;
            $error("FAIL seg frame=%0d cyc=%0d got=%h exp=%h", frame_no, e.cyc, seg, e.seg);
         end
         tests++;
         assert (frame_tick === e.tick) else begin
            fails++;
            $error("FAIL tick frame=%0d cyc=%0d got=%b exp=%b", frame_no, e.cyc, frame_tick, e.tick);
         end
      end
   endtask

   // Check n cycles at negedges; after checking cycle chg_cyc, apply the
   // pending displays/status (they must not show until the following frame).
   task automatic run_cycles(input int n, input int chg_cyc);
      for (int c = 0; c < n; c++) begin
         @(negedge clock);
         check_now();
         if (c == chg_cyc) begin
            for (int i = 0; i < 8; i++) displays[i] = pend_disp[i];
            status = pend_status;
         end
      end
      $display("[TB] frame %0d: %0d cycles checked, %0d failures so far", frame_no, n, fails);
      frame_no++;
   endtask

   task automatic run_frame(input bit blank, input bit first, input int chg_cyc);
      push_frame(blank, first);
      run_cycles(FRAME, chg_cyc);
   endtask

   task automatic check_reset_cycles();
      push_exp(8'hFF, BLANK, 1'b0, -1);
      check_now();
      repeat (2) begin
         @(negedge clock);
         push_exp(8'hFF, BLANK, 1'b0, -1);
         check_now();
      end
   endtask

   initial begin
      status = 2'b00;
      for (int i = 0; i < 8; i++) begin
         displays[i]  = 7'(8'h10 + i);
         pend_disp[i] = 7'(8'h10 + i);
      end
      pend_status = 2'b00;

      // Reset held: outputs blank, no tick.
      #1;
      check_reset_cycles();
      @(posedge clock);
      #2 reset = 1'b0;

      // Frame 0: shadow still holds reset blanks.
      for (int i = 0; i < 8; i++) frame_vals[i] = BLANK;
      run_frame(1'b0, 1'b1, -1);

      // Frames 1,2: scan order and wrap with the held patterns.
      for (int i = 0; i < 8; i++) frame_vals[i] = 7'(8'h10 + i);
      run_frame(1'b0, 1'b0, -1);
      run_frame(1'b0, 1'b0, -1);

      // Frame 3: change digit 3 while idx=5; frame 4 shows it, and raises error.
      pend_disp[3] = 7'h55;
      run_frame(1'b0, 1'b0, 5 * SCAN_DIV + 1);
      frame_vals[3] = 7'h55;
      pend_status = 2'b10;
      run_frame(1'b0, 1'b0, 10);

      // Frames 5..7: error blink lit, lit, blank; leave error during frame 7.
      run_frame(1'b0, 1'b0, -1);
      run_frame(1'b0, 1'b0, -1);
      pend_status = 2'b00;
      run_frame(1'b1, 1'b0, 5);

      // Frame 8: lit again; re-enter error, which must restart on a lit phase.
      pend_status = 2'b10;
      run_frame(1'b0, 1'b0, 5);
      run_frame(1'b0, 1'b0, -1);
      run_frame(1'b0, 1'b0, -1);
      run_frame(1'b1, 1'b0, -1);
      run_frame(1'b1, 1'b0, -1);
      pend_status = 2'b00;
      run_frame(1'b0, 1'b0, 7);
      run_frame(1'b0, 1'b0, -1);

      // Frame 15: abandon at idx=5, cnt=2 with an asynchronous reset.
      push_frame(1'b0, 1'b0);
      run_cycles(5 * SCAN_DIV + 3, -1);
      sb_q.delete();
      reset = 1'b1;
      #1;
      check_reset_cycles();
      @(posedge clock);
      #2 reset = 1'b0;

      // After release: blank frame with no tick at its start, then tick 32 later.
      for (int i = 0; i < 8; i++) frame_vals[i] = BLANK;
      run_frame(1'b0, 1'b1, -1);
      for (int i = 0; i < 8; i++) frame_vals[i] = 7'(8'h10 + i);
      frame_vals[3] = 7'h55;
      run_frame(1'b0, 1'b0, -1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
